// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/D memory-port arbiter: FSM states and port owners.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins outright; on a tie the
// port that did not win last time is chosen, so neither side can starve.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,    // bit 0 = IF, bit 1 = D
    input  owner_t     i_last,
    output logic       o_grant,
    output owner_t     o_owner
);

    always_comb begin
        o_grant = |i_req;
        o_owner = OWN_IF;
        case (i_req)
            2'b01:   o_owner = OWN_IF;
            2'b10:   o_owner = OWN_D;
            2'b11:   o_owner = (i_last == OWN_D) ? OWN_IF : OWN_D;
            default: o_owner = OWN_IF;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the CPU's IF and D ports, one
// transaction at a time, with a programmable access latency.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout,
    output logic        busy,
    output state_t      dbg_state
);

    state_t             r_state;
    owner_t             r_owner;
    owner_t             r_last;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_we;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_din;
    logic               r_mem_read;
    logic               r_mem_write;
    logic               r_if_ready;
    logic               r_d_ready;
    logic [31:0]        r_if_rdata;
    logic [31:0]        r_d_rdata;

    logic               w_grant;
    owner_t             w_owner;
    logic               w_new_we;

    rr_pick2 u_pick (
        .i_req   ({d_req, if_req}),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_owner (w_owner)
    );

    // Only the D port can write; an IF grant is always a read.
    assign w_new_we = (w_owner == OWN_D) && d_we;

    // Memory-side outputs are registered so they come straight from flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_owner     <= OWN_IF;
            r_last      <= OWN_D;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state     <= S_ACCESS;
                        r_owner     <= w_owner;
                        r_last      <= w_owner;
                        r_cnt       <= CNT_W'(MEM_LATENCY - 1);
                        r_we        <= w_new_we;
                        r_mem_addr  <= (w_owner == OWN_D) ? d_addr : if_addr;
                        r_mem_din   <= (w_owner == OWN_D) ? d_wdata : '0;
                        r_mem_read  <= !w_new_we;
                        // With a one-cycle access the only ACCESS cycle is the commit cycle.
                        r_mem_write <= w_new_we && (MEM_LATENCY == 1);
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == '0) begin
                        r_state     <= S_RESP;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        if (r_owner == OWN_IF) begin
                            r_if_rdata <= mem_dout;
                            r_if_ready <= 1'b1;
                        end else begin
                            r_d_rdata  <= r_we ? '0 : mem_dout;
                            r_d_ready  <= 1'b1;
                        end
                    end else begin
                        r_cnt       <= r_cnt - 1'b1;
                        r_mem_write <= r_we && (r_cnt == CNT_W'(1));
                    end
                end
                S_RESP: begin
                    r_state    <= S_IDLE;
                    r_if_ready <= 1'b0;
                    r_d_ready  <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_if_ready  <= 1'b0;
                    r_d_ready   <= 1'b0;
                end
            endcase
        end
    end

    assign if_ready  = r_if_ready;
    assign if_rdata  = r_if_rdata;
    assign d_ready   = r_d_ready;
    assign d_rdata   = r_d_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_din   = r_mem_din;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at latency 1, one at latency 3,
// each attached to its own word-addressed memory model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance 1: MEM_LATENCY = 1
    logic        if_req1, d_req1, d_we1;
    logic [31:0] if_addr1, d_addr1, d_wdata1;
    logic        if_ready1, d_ready1, mem_read1, mem_write1, busy1;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_din1, mem_dout1;
    state_t      st1;

    // Instance 3: MEM_LATENCY = 3
    logic        if_req3, d_req3, d_we3;
    logic [31:0] if_addr3, d_addr3, d_wdata3;
    logic        if_ready3, d_ready3, mem_read3, mem_write3, busy3;
    logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_din3, mem_dout3;
    state_t      st3;

    mem_port_arbiter #(.MEM_LATENCY(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req1), .if_addr(if_addr1), .if_ready(if_ready1), .if_rdata(if_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_ready(d_ready1), .d_rdata(d_rdata1),
        .mem_addr(mem_addr1), .mem_din(mem_din1), .mem_read(mem_read1),
        .mem_write(mem_write1), .mem_dout(mem_dout1), .busy(busy1), .dbg_state(st1)
    );

    mem_port_arbiter #(.MEM_LATENCY(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .reset(reset),
        .if_req(if_req3), .if_addr(if_addr3), .if_ready(if_ready3), .if_rdata(if_rdata3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_ready(d_ready3), .d_rdata(d_rdata3),
        .mem_addr(mem_addr3), .mem_din(mem_din3), .mem_read(mem_read3),
        .mem_write(mem_write3), .mem_dout(mem_dout3), .busy(busy3), .dbg_state(st3)
    );

    // Memory models: combinational read, write commits at the edge closing a mem_write cycle.
    logic [31:0] mem1 [0:255];
    logic [31:0] mem3 [0:255];
    logic        pl_we1 = 1'b0, pl_we3 = 1'b0;
    logic [7:0]  pl_idx1 = '0, pl_idx3 = '0;
    logic [31:0] pl_dat1 = '0, pl_dat3 = '0;

    assign mem_dout1 = mem1[mem_addr1[9:2]];
    assign mem_dout3 = mem3[mem_addr3[9:2]];

    always @(posedge clk) begin
        if (mem_write1)  mem1[mem_addr1[9:2]] <= mem_din1;
        else if (pl_we1) mem1[pl_idx1] <= pl_dat1;
        if (mem_write3)  mem3[mem_addr3[9:2]] <= mem_din3;
        else if (pl_we3) mem3[pl_idx3] <= pl_dat3;
    end

    // Edge counters of strobes, used to check pulse widths and totals.
    int wr_cnt1 = 0, wr_cnt3 = 0, rd_cnt3 = 0;
    always @(posedge clk) begin
        if (mem_write1) wr_cnt1 <= wr_cnt1 + 1;
        if (mem_write3) wr_cnt3 <= wr_cnt3 + 1;
        if (mem_read3)  rd_cnt3 <= rd_cnt3 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int which, input logic [7:0] idx, input logic [31:0] v);
        if (which == 1) begin
            pl_we1 = 1'b1; pl_idx1 = idx; pl_dat1 = v;
        end else begin
            pl_we3 = 1'b1; pl_idx3 = idx; pl_dat3 = v;
        end
        tick();
        pl_we1 = 1'b0;
        pl_we3 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        if_req1 = 1'b1; if_addr1 = 32'h40; d_req1 = 1'b1; d_we1 = 1'b0;
        d_addr1 = 32'h100; d_wdata1 = 32'h0;
        if_req3 = 1'b1; if_addr3 = 32'h40; d_req3 = 1'b1; d_we3 = 1'b0;
        d_addr3 = 32'h100; d_wdata3 = 32'h0;
        preload(1, 8'd16, 32'hDEADBEEF);
        preload(3, 8'd16, 32'h00C0FFEE);
        preload(3, 8'd128, 32'hA5A50003);
        preload(3, 8'd66, 32'h0BADF00D);
        tick();
        checks++;
        if ({if_ready1, d_ready1, mem_read1, mem_write1, busy1} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl1 got=%b exp=00000", {if_ready1, d_ready1, mem_read1, mem_write1, busy1});
        end
        checks++;
        if ({mem_addr1, mem_din1, if_rdata1, d_rdata1} !== 128'h0) begin
            failures++;
            $display("FAIL reset_data1 addr=%h din=%h ifr=%h dr=%h exp=0", mem_addr1, mem_din1, if_rdata1, d_rdata1);
        end
        checks++;
        if ({if_ready3, d_ready3, mem_read3, mem_write3, busy3} !== 5'b0 || mem_addr3 !== 32'h0) begin
            failures++;
            $display("FAIL reset_ctrl3 got=%b addr=%h exp=0", {if_ready3, d_ready3, mem_read3, mem_write3, busy3}, mem_addr3);
        end
        reset = 1'b1;
        tick();
        // Both requesting on the first grant: last_grant resets to D, so IF wins.
        checks++;
        if (mem_addr1 !== 32'h40 || mem_read1 !== 1'b1) begin
            failures++;
            $display("FAIL first_grant1 addr=%h rd=%b exp addr=00000040 rd=1", mem_addr1, mem_read1);
        end
        checks++;
        if (mem_addr3 !== 32'h40 || st3 !== S_ACCESS) begin
            failures++;
            $display("FAIL first_grant3 addr=%h st=%0d exp addr=00000040 st=1", mem_addr3, st3);
        end
        if_req1 = 1'b0; d_req1 = 1'b0; if_req3 = 1'b0; d_req3 = 1'b0;
        repeat (6) tick();
        checks++;
        if (busy1 !== 1'b0 || busy3 !== 1'b0 || if_rdata3 !== 32'h00C0FFEE) begin
            failures++;
            $display("FAIL reset_settle busy1=%b busy3=%b ifr3=%h exp 0 0 00c0ffee", busy1, busy3, if_rdata3);
        end
    endtask

    task automatic test_if_read();
        int w0;
        w0 = wr_cnt1;
        if_req1 = 1'b1; if_addr1 = 32'h40;
        tick();
        checks++;
        if (mem_read1 !== 1'b1 || if_ready1 !== 1'b0) begin
            failures++;
            $display("FAIL if_access rd=%b rdy=%b exp rd=1 rdy=0", mem_read1, if_ready1);
        end
        tick();
        checks++;
        if (if_ready1 !== 1'b1 || if_rdata1 !== 32'hDEADBEEF || d_ready1 !== 1'b0) begin
            failures++;
            $display("FAIL if_ready rdy=%b data=%h drdy=%b exp 1 deadbeef 0", if_ready1, if_rdata1, d_ready1);
        end
        if_req1 = 1'b0;
        tick();
        checks++;
        if (if_ready1 !== 1'b0 || busy1 !== 1'b0 || wr_cnt1 != w0 || if_rdata1 !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL if_done rdy=%b busy=%b writes=%0d data=%h exp 0 0 0 deadbeef", if_ready1, busy1, wr_cnt1 - w0, if_rdata1);
        end
    endtask

    task automatic test_d_write_read();
        int w0;
        w0 = wr_cnt1;
        d_req1 = 1'b1; d_we1 = 1'b1; d_addr1 = 32'h100; d_wdata1 = 32'h12345678;
        tick();
        checks++;
        if (mem_write1 !== 1'b1 || mem_read1 !== 1'b0 || mem_addr1 !== 32'h100 || mem_din1 !== 32'h12345678) begin
            failures++;
            $display("FAIL d_write_access wr=%b rd=%b addr=%h din=%h exp 1 0 00000100 12345678", mem_write1, mem_read1, mem_addr1, mem_din1);
        end
        tick();
        checks++;
        if (d_ready1 !== 1'b1 || d_rdata1 !== 32'h0 || mem_write1 !== 1'b0 || if_ready1 !== 1'b0) begin
            failures++;
            $display("FAIL d_write_resp rdy=%b rdata=%h wr=%b ifrdy=%b exp 1 0 0 0", d_ready1, d_rdata1, mem_write1, if_ready1);
        end
        checks++;
        if (wr_cnt1 - w0 != 1 || mem1[64] !== 32'h12345678) begin
            failures++;
            $display("FAIL d_write_commit pulses=%0d word=%h exp 1 12345678", wr_cnt1 - w0, mem1[64]);
        end
        d_req1 = 1'b0;
        tick();
        d_req1 = 1'b1; d_we1 = 1'b0; d_wdata1 = 32'hFFFFFFFF;
        tick();
        tick();
        checks++;
        if (d_ready1 !== 1'b1 || d_rdata1 !== 32'h12345678) begin
            failures++;
            $display("FAIL d_read_back rdy=%b rdata=%h exp 1 12345678", d_ready1, d_rdata1);
        end
        d_req1 = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        logic [31:0] exp_q[$];
        int n_rdy;
        // Last grant on this instance was D, so the tie starts with IF.
        exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
        n_rdy = 0;
        if_req1 = 1'b1; if_addr1 = 32'h40;
        d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 32'h100;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i == 11) begin
                if_req1 = 1'b0; d_req1 = 1'b0;
            end
            checks++;
            if (if_ready1 && d_ready1) begin
                failures++;
                $display("FAIL contention_both_ready cycle=%0d", i);
            end
            if (if_ready1 || d_ready1) begin
                logic [31:0] e;
                logic [31:0] got;
                n_rdy++;
                got = d_ready1 ? 32'd1 : 32'd0;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFFFFFF;
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL contention_order cycle=%0d owner=%0d exp=%0d", i, got, e);
                end
                checks++;
                if ((d_ready1 && d_rdata1 !== 32'h12345678) || (if_ready1 && if_rdata1 !== 32'hDEADBEEF)) begin
                    failures++;
                    $display("FAIL contention_data ifr=%h dr=%h exp deadbeef 12345678", if_rdata1, d_rdata1);
                end
            end
        end
        checks++;
        if (n_rdy != 4 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL contention_count readies=%0d left=%0d exp 4 0", n_rdy, exp_q.size());
        end
        tick();
    endtask

    task automatic test_lat3_read();
        int r0;
        r0 = rd_cnt3;
        d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 32'h200;
        tick();
        checks++;
        if (mem_read3 !== 1'b1 || mem_addr3 !== 32'h200) begin
            failures++;
            $display("FAIL lat3_access rd=%b addr=%h exp 1 00000200", mem_read3, mem_addr3);
        end
        tick();
        d_req3 = 1'b0;
        tick();
        checks++;
        if (d_ready3 !== 1'b0 || mem_read3 !== 1'b1) begin
            failures++;
            $display("FAIL lat3_early rdy=%b rd=%b exp 0 1", d_ready3, mem_read3);
        end
        tick();
        checks++;
        if (d_ready3 !== 1'b1 || d_rdata3 !== 32'hA5A50003 || mem_read3 !== 1'b0) begin
            failures++;
            $display("FAIL lat3_ready rdy=%b rdata=%h rd=%b exp 1 a5a50003 0", d_ready3, d_rdata3, mem_read3);
        end
        checks++;
        if (rd_cnt3 - r0 != 3) begin
            failures++;
            $display("FAIL lat3_read_cycles got=%0d exp=3", rd_cnt3 - r0);
        end
        tick();
        checks++;
        if (d_ready3 !== 1'b0 || busy3 !== 1'b0) begin
            failures++;
            $display("FAIL lat3_done rdy=%b busy=%b exp 0 0", d_ready3, busy3);
        end
    endtask

    task automatic test_reset_mid_write();
        int w0;
        w0 = wr_cnt3;
        d_req3 = 1'b1; d_we3 = 1'b1; d_addr3 = 32'h108; d_wdata3 = 32'hFFFFFFFF;
        tick();
        checks++;
        if (busy3 !== 1'b1 || mem_write3 !== 1'b0) begin
            failures++;
            $display("FAIL midw_access busy=%b wr=%b exp 1 0", busy3, mem_write3);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (st3 !== S_IDLE || busy3 !== 1'b0 || mem_addr3 !== 32'h0 || mem_write3 !== 1'b0) begin
            failures++;
            $display("FAIL midw_async st=%0d busy=%b addr=%h wr=%b exp 0 0 0 0", st3, busy3, mem_addr3, mem_write3);
        end
        d_req3 = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (4) tick();
        checks++;
        if (wr_cnt3 != w0 || mem3[66] !== 32'h0BADF00D || d_ready3 !== 1'b0) begin
            failures++;
            $display("FAIL midw_dropped writes=%0d word=%h rdy=%b exp 0 0badf00d 0", wr_cnt3 - w0, mem3[66], d_ready3);
        end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_d_write_read();
        test_contention();
        test_lat3_read();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
